// File: rtl/enc_byte_window.sv
// Word-to-byte window feeding the rANS state/pointer stage: captures the seed word,
// buffers later file words in a circular window and presents 3 bytes at EncPtr.
module enc_byte_window #(
   parameter int unsigned DEPTH_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        restart,
   input  logic [31:0] in_word,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] EncodedFileBottomWord,
   output logic        seed_valid,
   input  logic [31:0] EncPtr,
   output logic [23:0] EncBytes,
   output logic        window_valid,
   output logic        ptr_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {ST_ARM, ST_SEED, ST_FILL, ST_EOF} state_t;

   state_t        state, state_nx;
   logic [31:0]   mem [DEPTH_WORDS];
   logic [29:0]   wr_idx, base_idx;
   logic [CW-1:0] count;
   logic          last_seen;
   logic          xfer, push, pop, ptr_low;

   logic [32:0]   pos;
   logic [30:0]   pw;
   logic [23:0]   raw_bytes;
   logic          all_present;

   always_ff @(posedge clk) begin
      if (reset || restart) state <= ST_ARM;
      else                  state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      in_ready   = 1'b0;
      seed_valid = 1'b0;
      last_seen  = 1'b0;
      case (state)
         ST_ARM:  state_nx = ST_SEED;
         ST_SEED: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = in_last ? ST_EOF : ST_FILL;
         end
         ST_FILL: begin
            seed_valid = 1'b1;
            in_ready   = (count < CW'(DEPTH_WORDS));
            if (in_valid && in_ready && in_last) state_nx = ST_EOF;
         end
         ST_EOF: begin
            seed_valid = 1'b1;
            last_seen  = 1'b1;
         end
         default: state_nx = ST_ARM;
      endcase
      // a flush in progress must never look like an accepted word to the source
      if (reset || restart) in_ready = 1'b0;
   end

   assign xfer    = in_valid & in_ready;
   assign push    = xfer & (state == ST_FILL);
   assign pop     = (count != '0) && (EncPtr[31:2] > base_idx);
   assign ptr_low = seed_valid && (EncPtr[31:2] < base_idx);

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         wr_idx                <= 30'd1;
         base_idx              <= 30'd1;
         count                 <= '0;
         EncodedFileBottomWord <= '0;
         ptr_err               <= 1'b0;
      end else begin
         if (xfer && state == ST_SEED) EncodedFileBottomWord <= in_word;
         wr_idx   <= wr_idx + 30'(push);
         base_idx <= base_idx + 30'(pop);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
         if (ptr_low) ptr_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_idx[AW-1:0]] <= in_word;
   end

   // past-EOF bytes read as zero; positions below base or not yet written are absent
   always_comb begin
      all_present = 1'b1;
      raw_bytes   = '0;
      pos         = '0;
      pw          = '0;
      for (int unsigned k = 0; k < 3; k++) begin
         pos = {1'b0, EncPtr} + 33'(k);
         pw  = pos[32:2];
         if (pw < {1'b0, base_idx})
            all_present = 1'b0;
         else if (pw < {1'b0, wr_idx})
            raw_bytes[8*k +: 8] = mem[pw[AW-1:0]][{pos[1:0], 3'b000} +: 8];
         else if (!last_seen)
            all_present = 1'b0;
      end
   end

   assign window_valid = all_present & ~ptr_err;
   assign EncBytes     = window_valid ? raw_bytes : '0;

endmodule

// File: tb/tb_enc_byte_window.sv
// Bench for enc_byte_window: directed table/sequences, then random files checked
// against a byte-array model of the file and the consumer pointer.
module tb_enc_byte_window;

   logic        clk, reset, restart;
   logic [31:0] in_word;
   logic        in_valid, in_last, in_ready;
   logic [31:0] EncodedFileBottomWord;
   logic        seed_valid;
   logic [31:0] EncPtr;
   logic [23:0] EncBytes;
   logic        window_valid, ptr_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] ptr;
      logic [23:0] bytes;
      logic        valid;
   } vec_t;
   vec_t tbl [10];

   logic [31:0] fw [$];

   enc_byte_window #(.DEPTH_WORDS(4)) dut (
      .clk(clk), .reset(reset), .restart(restart),
      .in_word(in_word), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .EncodedFileBottomWord(EncodedFileBottomWord), .seed_valid(seed_valid),
      .EncPtr(EncPtr), .EncBytes(EncBytes), .window_valid(window_valid), .ptr_err(ptr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      int unsigned n = 0;
      @(negedge clk);
      in_word = w; in_last = last; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("handshake", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_restart();
      @(negedge clk); restart = 1'b1;
      @(negedge clk); restart = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned armed, n_acc, base, last, ptr, pv, n, wr, cnt, seeded, er, ev, p, w, done;
      logic [23:0] eb;
      logic [31:0] tmp;

      clk = 0; reset = 1; restart = 0;
      in_valid = 0; in_word = 0; in_last = 0; EncPtr = 0;

      tbl[0] = '{32'd4,  24'hA2A1A0, 1'b1};
      tbl[1] = '{32'd5,  24'hA3A2A1, 1'b1};
      tbl[2] = '{32'd6,  24'hB0A3A2, 1'b1};
      tbl[3] = '{32'd7,  24'hB1B0A3, 1'b1};
      tbl[4] = '{32'd8,  24'hB2B1B0, 1'b1};
      tbl[5] = '{32'd10, 24'hC0B3B2, 1'b1};
      tbl[6] = '{32'd11, 24'hC1C0B3, 1'b1};
      tbl[7] = '{32'd13, 24'hC3C2C1, 1'b1};
      tbl[8] = '{32'd14, 24'h00C3C2, 1'b1};
      tbl[9] = '{32'd16, 24'h000000, 1'b1};

      // reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_seed_valid", {31'd0, seed_valid}, 32'd0);
      chk("rst_seed_word", EncodedFileBottomWord, 32'd0);
      chk("rst_bytes", {8'd0, EncBytes}, 32'd0);
      chk("rst_window_valid", {31'd0, window_valid}, 32'd0);
      chk("rst_ptr_err", {31'd0, ptr_err}, 32'd0);
      @(negedge clk); reset = 0; EncPtr = 4;
      #1 chk("ready_first_cycle", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      #1 chk("ready_second_cycle", {31'd0, in_ready}, 32'd1);

      // seed capture, then table reads over a 3-word body ending in EOF
      send_word(32'h11223344, 1'b0);
      chk("seed_valid", {31'd0, seed_valid}, 32'd1);
      chk("seed_word", EncodedFileBottomWord, 32'h11223344);
      chk("empty_window", {31'd0, window_valid}, 32'd0);
      send_word(32'hA3A2A1A0, 1'b0);
      send_word(32'hB3B2B1B0, 1'b0);
      send_word(32'hC3C2C1C0, 1'b1);
      chk("ready_after_last", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); EncPtr = tbl[i].ptr;
         #1;
         chk($sformatf("tbl_valid[%0d]", i), {31'd0, window_valid}, {31'd0, tbl[i].valid});
         chk($sformatf("tbl_bytes[%0d]", i), {8'd0, EncBytes}, {8'd0, tbl[i].bytes});
      end

      // full window, pop and accept on the following cycle
      EncPtr = 4;
      do_restart();
      #1;
      chk("restart_seed_valid", {31'd0, seed_valid}, 32'd0);
      chk("restart_in_ready", {31'd0, in_ready}, 32'd0);
      send_word(32'h55555555, 1'b0);
      for (int i = 1; i <= 4; i++) send_word(32'h01010101 * i, 1'b0);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      in_valid = 1'b1; in_word = 32'h05050505; EncPtr = 8;
      #1 chk("full_pop_cycle_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1 chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("refull_ready", {31'd0, in_ready}, 32'd0);
      chk("full_read_bytes", {8'd0, EncBytes}, 32'h00020202);
      @(negedge clk); EncPtr = 19;
      #1 chk("wrap_slot_valid", {31'd0, window_valid}, 32'd1);
      chk("wrap_slot_bytes", {8'd0, EncBytes}, 32'h00050504);

      // starve across a word straddle
      EncPtr = 4;
      do_restart();
      send_word(32'h99999999, 1'b0);
      send_word(32'h13121110, 1'b0);
      @(negedge clk); EncPtr = 7;
      #1 chk("starve_valid", {31'd0, window_valid}, 32'd0);
      @(negedge clk); in_valid = 1'b1; in_word = 32'h23222120;
      #1 chk("starve_before_accept", {31'd0, window_valid}, 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("straddle_valid", {31'd0, window_valid}, 32'd1);
      chk("straddle_bytes", {8'd0, EncBytes}, 32'h00212013);

      // pointer error is sticky until restart
      send_word(32'h33323130, 1'b0);
      @(negedge clk); EncPtr = 12;
      repeat (3) @(negedge clk);
      #1 chk("ptr12_valid", {31'd0, window_valid}, 32'd1);
      chk("ptr12_bytes", {8'd0, EncBytes}, 32'h00323130);
      @(negedge clk); EncPtr = 4;
      #1 chk("err_not_yet", {31'd0, ptr_err}, 32'd0);
      @(posedge clk);
      #1 chk("err_set", {31'd0, ptr_err}, 32'd1);
      chk("err_blocks_valid", {31'd0, window_valid}, 32'd0);
      @(negedge clk); EncPtr = 12;
      repeat (2) @(negedge clk);
      #1 chk("err_sticky", {31'd0, ptr_err}, 32'd1);
      chk("err_sticky_valid", {31'd0, window_valid}, 32'd0);
      do_restart();
      #1 chk("err_cleared", {31'd0, ptr_err}, 32'd0);
      chk("err_restart_seed", {31'd0, seed_valid}, 32'd0);
      EncPtr = 4;
      send_word(32'hDEADBEEF, 1'b1);
      chk("new_seed", EncodedFileBottomWord, 32'hDEADBEEF);
      chk("seed_eof_ready", {31'd0, in_ready}, 32'd0);
      chk("seed_eof_valid", {31'd0, window_valid}, 32'd1);
      chk("seed_eof_bytes", {8'd0, EncBytes}, 32'd0);

      // random files against a byte-level model
      for (int f = 0; f < 12; f++) begin
         n = $urandom_range(1, 10);
         fw.delete();
         for (int i = 0; i < int'(n); i++) fw.push_back($urandom);
         EncPtr = 4;
         do_restart();
         armed = 0; n_acc = 0; base = 1; last = 0; ptr = 4; pv = 0; done = 0;
         for (int c = 0; c < 400 && done == 0; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_word  = (n_acc < n) ? fw[n_acc] : $urandom;
            in_last  = (n_acc == n - 1);
            if (pv != 0) ptr = ptr + $urandom_range(0, 3);
            EncPtr = ptr;
            #1;
            seeded = (n_acc > 0);
            wr  = (n_acc == 0) ? 1 : n_acc;
            cnt = wr - base;
            er  = (armed != 0 && (seeded == 0 || (last == 0 && cnt < 4))) ? 1 : 0;
            ev  = 1; eb = '0;
            for (int k = 0; k < 3; k++) begin
               p = ptr + k;
               w = p / 4;
               if (w < base) ev = 0;
               else if (w < wr) begin
                  tmp = fw[w] >> (8 * (p % 4));
                  eb[8*k +: 8] = tmp[7:0];
               end
               else if (last == 0) ev = 0;
            end
            chk("rand_ready", {31'd0, in_ready}, er);
            chk("rand_valid", {31'd0, window_valid}, ev);
            if (ev != 0) chk("rand_bytes", {8'd0, EncBytes}, {8'd0, eb});
            chk("rand_seed_valid", {31'd0, seed_valid}, seeded);
            if (seeded != 0) chk("rand_seed", EncodedFileBottomWord, fw[0]);
            chk("rand_ptr_err", {31'd0, ptr_err}, 32'd0);
            if (cnt > 0 && ptr / 4 > base) base++;
            if (in_valid && er != 0) begin
               n_acc++;
               if (in_last) last = 1;
            end
            armed = 1;
            pv = ev;
            if (last != 0 && ptr >= n * 4 + 4) done = 1;
            @(negedge clk);
         end
         in_valid = 1'b0; in_last = 1'b0;
         chk("rand_eof_reached", done, 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
